// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    WRITE,
    DONE,
    ERROR
  } state_t;

  // Byte distance between consecutive instruction words (matches PC increment).
  localparam logic [15:0] IM_WORD_STRIDE   = 16'd2;
  // The image header is a big-endian word count of this many bytes.
  localparam int          LOADER_LEN_BYTES = 2;

endpackage

// File: rtl/byte_pair_assembler.sv
// Joins a hi byte and the following lo byte into one big-endian 16-bit word.
// The word is presented combinationally alongside the lo-byte handshake so the
// caller can register it on the same edge that accepts the lo byte.
module byte_pair_assembler (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_hi_xfer,
  input  logic        i_lo_xfer,
  input  logic [7:0]  i_byte,
  output logic [15:0] o_word,
  output logic        o_word_valid
);

  logic [7:0] r_hi;

  // Hold the high byte until its partner arrives.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hi <= 8'h00;
    end else if (i_hi_xfer) begin
      r_hi <= i_byte;
    end
  end

  assign o_word       = {r_hi, i_byte};
  assign o_word_valid = i_lo_xfer;

endmodule

// File: rtl/program_loader.sv
// Boot loader: receives a length-prefixed byte image, writes 16-bit words into
// instruction memory at consecutive addresses, and keeps the CPU in reset
// until the whole image has landed.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   IDLE    | after reset, waiting for start
//   LEN_HI  | waiting for high byte of word count
//   LEN_LO  | waiting for low byte of word count, then range check
//   DATA_HI | waiting for high byte of next word
//   DATA_LO | waiting for low byte of next word
//   WRITE   | one-cycle instruction-memory write
//   DONE    | image complete, CPU released
//   ERROR   | bad word count, CPU held, sticky until start/rst
module program_loader
  import loader_pkg::*;
#(
  parameter int          MAX_WORDS = 256,
  parameter logic [15:0] BASE_ADDR = 16'h0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte_data,
  output logic        o_byte_ready,
  output logic        o_im_we,
  output logic [15:0] o_im_addr,
  output logic [15:0] o_im_wdata,
  output logic        o_cpu_rst,
  output logic        o_done,
  output logic        o_error,
  output logic [15:0] o_words_loaded
);

  localparam int          LEN_W   = 8 * LOADER_LEN_BYTES;
  // One extra bit so a MAX_WORDS of 65536 would still compare correctly.
  localparam logic [LEN_W:0] MAX_LEN = (LEN_W + 1)'(MAX_WORDS);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_byte_ready;
  logic               w_xfer;
  logic               w_start_load;
  logic [LEN_W-1:0]   w_len_full;
  logic [7:0]         r_len_hi;
  logic [LEN_W-1:0]   r_len;
  logic [15:0]        r_im_addr;
  logic [15:0]        r_im_wdata;
  logic [15:0]        r_words_loaded;
  logic               r_cpu_rst;
  logic [15:0]        w_word;
  logic               w_word_valid;

  assign w_xfer     = i_byte_valid & w_byte_ready;
  assign w_len_full = {r_len_hi, i_byte_data};

  byte_pair_assembler u_asm (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_hi_xfer    (w_xfer && (r_state == DATA_HI)),
    .i_lo_xfer    (w_xfer && (r_state == DATA_LO)),
    .i_byte       (i_byte_data),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-state strobes; byte_ready depends on state alone.
  always_comb begin
    w_state_nxt  = r_state;
    w_byte_ready = 1'b0;
    w_start_load = 1'b0;
    case (r_state)
      IDLE, DONE, ERROR: begin
        if (i_start) begin
          w_state_nxt  = LEN_HI;
          w_start_load = 1'b1;
        end
      end
      LEN_HI: begin
        w_byte_ready = 1'b1;
        if (w_xfer) w_state_nxt = LEN_LO;
      end
      LEN_LO: begin
        w_byte_ready = 1'b1;
        if (w_xfer) begin
          if ((w_len_full == '0) || ({1'b0, w_len_full} > MAX_LEN)) begin
            w_state_nxt = ERROR;
          end else begin
            w_state_nxt = DATA_HI;
          end
        end
      end
      DATA_HI: begin
        w_byte_ready = 1'b1;
        if (w_xfer) w_state_nxt = DATA_LO;
      end
      DATA_LO: begin
        w_byte_ready = 1'b1;
        if (w_xfer) w_state_nxt = WRITE;
      end
      WRITE: begin
        if ((r_words_loaded + 16'd1) == r_len) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = DATA_HI;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Length capture, write datapath, address/word counters and CPU reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_len_hi       <= 8'h00;
      r_len          <= '0;
      r_im_addr      <= BASE_ADDR;
      r_im_wdata     <= 16'h0000;
      r_words_loaded <= 16'h0000;
      r_cpu_rst      <= 1'b1;
    end else begin
      // Registered so it falls entering DONE and rises on the edge leaving it.
      r_cpu_rst <= (w_state_nxt != DONE);
      if (w_xfer && (r_state == LEN_HI)) r_len_hi <= i_byte_data;
      if (w_xfer && (r_state == LEN_LO)) r_len    <= w_len_full;
      if (w_word_valid) r_im_wdata <= w_word;
      if (w_start_load) begin
        r_im_addr      <= BASE_ADDR;
        r_words_loaded <= 16'h0000;
      end else if (r_state == WRITE) begin
        r_im_addr      <= r_im_addr + IM_WORD_STRIDE;
        r_words_loaded <= r_words_loaded + 16'd1;
      end
    end
  end

  assign o_byte_ready   = w_byte_ready;
  assign o_im_we        = (r_state == WRITE);
  assign o_im_addr      = r_im_addr;
  assign o_im_wdata     = r_im_wdata;
  assign o_cpu_rst      = r_cpu_rst;
  assign o_done         = (r_state == DONE);
  assign o_error        = (r_state == ERROR);
  assign o_words_loaded = r_words_loaded;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: drives at negedge, samples at negedge.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        bv;
  logic [7:0]  bd;
  logic        ready;
  logic        we;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        cpu_rst;
  logic        done;
  logic        error;
  logic [15:0] words;

  always #5 clk = ~clk;

  program_loader #(.MAX_WORDS(256), .BASE_ADDR(16'h0000)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_start        (start),
    .i_byte_valid   (bv),
    .i_byte_data    (bd),
    .o_byte_ready   (ready),
    .o_im_we        (we),
    .o_im_addr      (addr),
    .o_im_wdata     (wdata),
    .o_cpu_rst      (cpu_rst),
    .o_done         (done),
    .o_error        (error),
    .o_words_loaded (words)
  );

  int          n_chk = 0;
  int          n_pass = 0;
  int          rdy_viol = 0;
  logic [31:0] wr_q[$];
  logic [31:0] exp_q[$];
  logic [7:0]  tx_q[$];

  // Record every memory write as {addr,data}; byte_ready must be low then.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      wr_q.push_back({addr, wdata});
      if (ready !== 1'b0) rdy_viol++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    int n;
    gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    repeat (gap) begin
      bv = 1'b0;
      @(negedge clk);
    end
    bv = 1'b1;
    bd = b;
    n  = 0;
    while (ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("byte_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    bv = 1'b0;
  endtask

  task automatic send_q(input int max_gap);
    while (tx_q.size() > 0) send_byte(tx_q.pop_front(), max_gap);
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_nwr"}, wr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < wr_q.size()) chk({tag, "_wr"}, wr_q[i], exp_q[i]);
  endtask

  task automatic load_nominal(input int max_gap);
    tx_q  = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'hFF};
    exp_q = '{32'h0000_1234, 32'h0002_ABCD, 32'h0004_00FF};
    send_q(max_gap);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bv = 1'b0; bd = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_ctl",  {27'd0, ready, we, cpu_rst, done, error}, 32'h4);
    chk("rst_addr", {addr, wdata}, 32'h0);
    chk("rst_words", words, 32'h0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_cpu_rst", cpu_rst, 32'h1);
    chk("idle_ready", ready, 32'h0);
    chk("idle_nwr", wr_q.size(), 32'h0);

    // Nominal 3-word image, no gaps.
    pulse_start();
    load_nominal(0);
    chk("nom_last_write_cpu_rst", {we, cpu_rst}, 32'h3);
    @(negedge clk);
    chk("nom_done", {done, cpu_rst, error}, 32'h4);
    chk("nom_words", words, 32'd3);
    chk("nom_addr_after", addr, 32'h0006);
    check_writes("nom");

    // Reload from DONE with a single word.
    wr_q.delete();
    pulse_start();
    chk("reload_cleared", {cpu_rst, done, words, addr}, {1'b1, 1'b0, 16'h0, 16'h0});
    tx_q  = '{8'h00, 8'h01, 8'h55, 8'hAA};
    exp_q = '{32'h0000_55AA};
    send_q(0);
    @(negedge clk);
    chk("reload_done", {done, cpu_rst}, 32'h2);
    chk("reload_words", words, 32'd1);
    check_writes("reload");

    // Same image with random gaps on byte_valid.
    wr_q.delete();
    rdy_viol = 0;
    pulse_start();
    load_nominal(3);
    @(negedge clk);
    chk("bp_done", {done, cpu_rst}, 32'h2);
    chk("bp_words", words, 32'd3);
    check_writes("bp");
    chk("bp_ready_in_write", rdy_viol, 32'd0);

    // Zero length -> ERROR, sticky, no writes.
    wr_q.delete();
    pulse_start();
    tx_q = '{8'h00, 8'h00};
    send_q(0);
    chk("len0_err", {error, cpu_rst, done}, 32'h6);
    repeat (3) @(negedge clk);
    chk("len0_sticky", {error, ready}, 32'h2);
    chk("len0_nwr", wr_q.size(), 32'd0);

    // 257 words -> ERROR; start from ERROR clears it first.
    pulse_start();
    chk("err_cleared", {error, ready}, 32'h1);
    tx_q = '{8'h01, 8'h01};
    send_q(0);
    chk("len257_err", {error, cpu_rst}, 32'h3);

    // Exactly MAX_WORDS = 256 is accepted and fully loaded.
    wr_q.delete();
    rdy_viol = 0;
    pulse_start();
    tx_q = '{8'h01, 8'h00};
    send_q(0);
    chk("len256_ok", {error, ready}, 32'h1);
    for (int i = 0; i < 256; i++) begin
      tx_q.push_back(8'(i));
      tx_q.push_back(~8'(i));
    end
    send_q(0);
    @(negedge clk);
    chk("len256_done", {done, cpu_rst}, 32'h2);
    chk("len256_words", words, 32'h0100);
    chk("len256_nwr", wr_q.size(), 32'd256);
    if (wr_q.size() == 256) begin
      chk("len256_first", wr_q[0], 32'h0000_00FF);
      chk("len256_last", wr_q[255], 32'h01FE_FF00);
    end
    chk("len256_ready_in_write", rdy_viol, 32'd0);

    // Reset after the first of three words, mid-way into the second.
    wr_q.delete();
    pulse_start();
    tx_q = '{8'h00, 8'h03, 8'h12, 8'h34};
    send_q(0);
    @(negedge clk);
    tx_q = '{8'hAB};
    send_q(0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ctl",  {27'd0, ready, we, cpu_rst, done, error}, 32'h4);
    chk("midrst_addr", {addr, wdata}, 32'h0);
    chk("midrst_words", words, 32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    exp_q = '{32'h0000_1234};
    check_writes("midrst");
    wr_q.delete();
    pulse_start();
    load_nominal(1);
    @(negedge clk);
    chk("after_rst_done", {done, cpu_rst}, 32'h2);
    check_writes("after_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time loader directly upstream of the CPU's instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles it into 16-bit big-endian instruction words.
- Writes each word into instruction memory at consecutive byte addresses (stride 2, matching the PC increment).
- Holds the CPU in reset until the full image is written.

Parameters:
- MAX_WORDS, 256, largest accepted image size in words.
- BASE_ADDR, 16'h0000, instruction-memory byte address of word 0.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- byte_valid  input  1  upstream byte present.
- byte_data  input  8  upstream byte.
- byte_ready  output  1  loader accepts byte_data this cycle.
- im_we  output  1  instruction-memory write strobe.
- im_addr  output  16  instruction-memory byte address.
- im_wdata  output  16  instruction word to write.
- cpu_rst  output  1  reset to CPU; high while no valid image is loaded.
- done  output  1  image loaded successfully.
- error  output  1  load aborted because of a bad length.
- words_loaded  output  16  count of words written in the current load.

Behaviour:
- One clock. Reset is synchronous and active-high: clk and rst only.
- Reset values:
  - state=IDLE; cpu_rst=1.
  - byte_ready, im_we, done, error = 0.
  - im_addr=BASE_ADDR; im_wdata=0; words_loaded=0.
- Handshake: a byte transfers on a clk edge where byte_valid && byte_ready. byte_ready depends only on state, never on byte_valid.
- Stream format: len_hi, len_lo (word count N, big-endian), then N words, each as hi byte then lo byte.
- States:
  - IDLE: byte_ready=0. start -> LEN_HI.
  - LEN_HI: byte_ready=1. On transfer, latch len[15:8] -> LEN_LO.
  - LEN_LO: byte_ready=1. On transfer, latch len[7:0], then:
    - if {len_hi,byte_data}==0 or >MAX_WORDS -> ERROR;
    - else -> DATA_HI.
  - DATA_HI: byte_ready=1. On transfer, latch word[15:8] -> DATA_LO.
  - DATA_LO: byte_ready=1. On transfer, im_wdata <= {hi,byte} -> WRITE.
  - WRITE: byte_ready=0. im_we=1 for exactly one cycle with the current im_addr/im_wdata. Next cycle:
    - im_addr += 2;
    - words_loaded += 1;
    - if words_loaded+1==N -> DONE, else -> DATA_HI.
  - DONE: done=1, cpu_rst=0, byte_ready=0. start -> LEN_HI, and on the same edge: cpu_rst=1, done=0, words_loaded=0, im_addr=BASE_ADDR.
  - ERROR: error=1, cpu_rst=1, byte_ready=0. Sticky until rst, or start -> LEN_HI with error cleared.
- cpu_rst is registered:
  - 0 only in DONE;
  - rises on the same edge that leaves DONE;
  - falls on the edge entering DONE.
- start outside IDLE/DONE/ERROR is ignored; a load in progress is never restarted.
- rst mid-load: abandons the load immediately. No further im_we. All outputs return to reset values the following cycle. Memory contents already written are not scrubbed.
- Addresses: im_addr = BASE_ADDR + 2*words_loaded, 16-bit wrapping.
- Throughput: at most one word per 3 cycles (2 byte transfers + 1 WRITE).
- Stalls: byte_valid low in any receive state holds the state indefinitely; no timeout.
- im_wdata/im_addr hold their last values outside WRITE.

Decomposition:
- Shared package loader_pkg:
  - state enum {IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, DONE, ERROR};
  - constant IM_WORD_STRIDE=2;
  - constant LOADER_LEN_BYTES=2.
- One natural sub-module, byte_pair_assembler: captures the hi/lo bytes on handshake and outputs the 16-bit word plus a word_valid pulse.
- FSM, address counter and cpu_rst logic stay in program_loader.

Test Plan:
- Reset then idle: rst=1 two cycles, release, no start -> cpu_rst=1, byte_ready=0, im_we never asserted for 20 cycles.
- Nominal 3-word load:
  - stimulus: start, stream 00 03 | 12 34 | AB CD | 00 FF with byte_valid always 1;
  - response: im_we pulses with (addr,data) = (0000,1234), (0002,ABCD), (0004,00FF); done=1 and cpu_rst=0 on the cycle after the third write; words_loaded=3.
- Backpressure/gaps: same image with byte_valid toggled randomly -> identical writes, no duplicate or dropped bytes, byte_ready low in every WRITE cycle.
- Bad length:
  - stream 00 00 -> ERROR, error=1, cpu_rst=1, no im_we;
  - stream 01 01 with MAX_WORDS=256 -> ERROR;
  - stream 01 00 (=256) -> accepted.
- Reset mid-load: assert rst after 1 of 3 words written -> next cycle all outputs at reset values; a new start and full image then load correctly from BASE_ADDR.
- Reload from DONE: after a successful load, start with 00 01 | 55 AA -> cpu_rst rises on the start edge, single write (0000,55AA), done again with words_loaded=1.
